// File: rtl/uart_tx_fifo_if.sv
// Handshake bundle between the APB UART slave / serializer and the TX byte FIFO.
// The master modport is the user side; the slave modport is the FIFO itself.
interface uart_tx_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16
);
  logic                          wren_tx;
  logic [DATA_WIDTH-1:0]         tx_fifo_data;
  logic                          rden_tx;
  logic                          err_clr;
  logic [DATA_WIDTH-1:0]         tx_rd_data;
  logic                          tx_rd_valid;
  logic                          tx_full;
  logic                          tx_empty;
  logic                          tx_almost_full;
  logic [$clog2(FIFO_DEPTH):0]   tx_count;
  logic                          tx_overflow;
  logic                          tx_underflow;

  modport master (
    output wren_tx, tx_fifo_data, rden_tx, err_clr,
    input  tx_rd_data, tx_rd_valid, tx_full, tx_empty, tx_almost_full,
           tx_count, tx_overflow, tx_underflow
  );

  modport slave (
    input  wren_tx, tx_fifo_data, rden_tx, err_clr,
    output tx_rd_data, tx_rd_valid, tx_full, tx_empty, tx_almost_full,
           tx_count, tx_overflow, tx_underflow
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Transmit byte FIFO for the APB UART with registered status flags and sticky errors.
// Define UART_TX_FIFO_FWFT_EN for first-word-fall-through reads; default is a registered read.
module uart_tx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int AF_LEVEL   = 12
) (
  input logic          PCLK,
  input logic          PReset,
  uart_tx_fifo_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  af_q, af_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  push_ok, pop_ok;

  // A pop frees a slot on the same edge, so a push into a full FIFO is legal alongside it.
  always_comb begin
    pop_ok   = bus.rden_tx && !empty_q;
    push_ok  = bus.wren_tx && (!full_q || pop_ok);
    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CW'(FIFO_DEPTH));
    empty_d = (count_d == '0);
    af_d    = (count_d >= CW'(AF_LEVEL));
    ovf_d   = (bus.wren_tx && !push_ok) ? 1'b1 : (bus.err_clr ? 1'b0 : ovf_q);
    unf_d   = (bus.rden_tx && empty_q)  ? 1'b1 : (bus.err_clr ? 1'b0 : unf_q);
  end

  always_ff @(posedge PCLK) begin
    if (PReset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      af_q     <= af_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  always_ff @(posedge PCLK) begin
    if (!PReset && push_ok)
      mem_q[wr_ptr_q] <= bus.tx_fifo_data;
  end

`ifdef UART_TX_FIFO_FWFT_EN
  assign bus.tx_rd_data  = mem_q[rd_ptr_q];
  assign bus.tx_rd_valid = !empty_q;
`else
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;

  always_comb begin
    rd_data_d  = pop_ok ? mem_q[rd_ptr_q] : rd_data_q;
    rd_valid_d = pop_ok;
  end

  always_ff @(posedge PCLK) begin
    if (PReset) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign bus.tx_rd_data  = rd_data_q;
  assign bus.tx_rd_valid = rd_valid_q;
`endif

  assign bus.tx_full        = full_q;
  assign bus.tx_empty       = empty_q;
  assign bus.tx_almost_full = af_q;
  assign bus.tx_count       = count_q;
  assign bus.tx_overflow    = ovf_q;
  assign bus.tx_underflow   = unf_q;
endmodule
